bambu_putchar_fifo: RTL and testbench
=====================================

// Module: bambu_putchar_fifo
// PURPOSE
//  Parametrised putchar backend for Bambu-generated cores. A start/done call pushes one character into an internal FIFO of DEPTH entries.
//  An independent drain FSM feeds the FIFO to the UART TX interface one character per TX_READY.
//  Generalised in width and depth over the fixed 8-bit putchar; adds occupancy/idle status and an optional LF->CRLF expansion.
// PARAMETERS
//  DATA_W   8    character width in bits (TX_DATA, c, return_port)
//  DEPTH    16   FIFO entries; power of two, >=2
//  LEVEL_W  $clog2(DEPTH)+1  occupancy width (derived, not overridden)
// PORTS
//  clock        in   1        single clock, all logic posedge
//  reset_n      in   1        asynchronous, active-low reset
//  start_port   in   1        call request, 1-cycle pulse, sampled only in ACC_IDLE
//  c            in   DATA_W   character to emit, sampled with start_port
//  done_port    out  1        call complete, 1-cycle pulse
//  return_port  out  DATA_W   c echoed while done_port=1, else 0
//  TX_DATA      out  DATA_W   byte to UART, valid with TX_ENABLE
//  TX_ENABLE    out  1        1-cycle transmit strobe
//  TX_READY     in   1        UART able to accept a byte
//  fifo_level   out  LEVEL_W  current FIFO occupancy, 0..DEPTH
//  tx_idle      out  1        1 when FIFO empty and drain FSM in TX_IDLE
// BEHAVIOUR
//  Reset (reset_n=0, any time, incl. mid-call): done_port=0, return_port=0, TX_DATA=0, TX_ENABLE=0, fifo_level=0, tx_idle=1.
//   Both FSMs go to IDLE and FIFO contents are discarded; no partial call completes.
//  All outputs are registered.
//  Accept FSM: ACC_IDLE -> ACC_PUSH -> ACC_IDLE.
//   ACC_IDLE: start_port=1 latches c and moves to ACC_PUSH. start_port in any other state is ignored.
//   ACC_PUSH: if !full at the edge, write the latched char, pulse done_port, return_port=char, then go to ACC_IDLE.
//    If full, stall in ACC_PUSH, with no timeout and done_port held 0.
//   Minimum latency: start sampled at edge k -> done_port=1 in the cycle after edge k+1.
//  Drain FSM: TX_IDLE -> TX_SEND -> TX_GAP -> TX_IDLE.
//   TX_IDLE: !empty && TX_READY pops the head and moves to TX_SEND.
//   TX_SEND: TX_DATA=popped head, TX_ENABLE=1 for exactly one cycle.
//   TX_GAP: one dead cycle so the UART can drop TX_READY; TX_ENABLE=0.
//   Maximum throughput: 1 char per 3 cycles. TX_DATA holds its last value when not strobed.
//  Full/empty come from the registered occupancy count. A push is refused when level==DEPTH, even if a pop occurs at the same edge.
//   There is no push-to-pop bypass, and an empty FIFO never pops.
//  A push and a pop at the same edge leave fifo_level unchanged. Pointers wrap modulo DEPTH.
//  FIFO order is strictly preserved; no character is dropped or duplicated.
// CONFIGURATION
//  PUTCHAR_CRLF_EN defined:
//   When the latched c == LF (0x0A), the accept FSM goes ACC_PUSH_CR -> ACC_PUSH.
//   CR (0x0D) is pushed first, then LF. Each push waits independently for !full.
//   done_port pulses once, after the LF push; return_port = 0x0A. Minimum latency is 3 edges.
//   Requires DATA_W>=8.
//  Undefined: all values pass through unchanged and the ACC_PUSH_CR state does not exist.
// STRUCTURE
//  Package bambu_io_pkg: accept/drain FSM state enums, and CHAR_LF=8'h0A and CHAR_CR=8'h0D constants.
//  Sub-module bambu_io_fifo #(DATA_W,DEPTH): reg-array FIFO with async active-low reset and registered level/full/empty.
//   Read data is valid the cycle after rd_en.
//  The top level holds both FSMs and the output registers only.
// TESTING
//  1 Reset mid-call:
//   Assert start, c=0x41; drop reset_n for 1 cycle before done.
//   -> done never pulses, fifo_level=0, tx_idle=1, TX_ENABLE stays 0.
//  2 Single char:
//   TX_READY=1, start with c=0x48.
//   -> done_port=1 and return_port=0x48 in cycle k+2; exactly one TX_ENABLE with TX_DATA=0x48; tx_idle returns to 1.
//  3 Fill to full:
//   TX_READY=0, push DEPTH chars 0x00..0x0F; fifo_level=16.
//   Then push 0x55 -> done stalls.
//   Raise TX_READY -> 0x00 drains, 0x55 is accepted, and the order 0x01..0x0F,0x55 follows.
//  4 Backpressure:
//   Toggle TX_READY randomly while streaming 100 chars.
//   -> every TX_ENABLE occurs only after TX_IDLE with TX_READY=1, with no loss, duplication or reordering.
//  5 Simultaneous push/pop at level=DEPTH-1:
//   -> level stays DEPTH-1. Wrap-around is checked over 3*DEPTH chars.
//  6 PUTCHAR_CRLF_EN:
//   Send "A\n".
//   -> TX sequence 0x41,0x0D,0x0A; one done per call; the LF call returns 0x0A.
//   Without the macro: TX sequence 0x41,0x0A.

Source files
------------

// File: rtl/bambu_io_pkg.sv
// ============================================================================
//  Module   : bambu_io_pkg
//  Brief    : FSM state types and character constants for the putchar FIFO.
//             Macro PUTCHAR_CRLF_EN adds the CR-insertion accept state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bambu_io_pkg;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic [1:0] {
        ACC_IDLE    = 2'd0,
        ACC_PUSH    = 2'd1
`ifdef PUTCHAR_CRLF_EN
        ,
        ACC_PUSH_CR = 2'd2
`endif
    } acc_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/bambu_putchar_fifo_if.sv
// ============================================================================
//  Module   : bambu_putchar_fifo_if
//  Brief    : Call handshake, UART TX and status signals of the putchar FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bambu_putchar_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               start_port;
    logic [DATA_W-1:0]  c;
    logic               done_port;
    logic [DATA_W-1:0]  return_port;
    logic [DATA_W-1:0]  TX_DATA;
    logic               TX_ENABLE;
    logic               TX_READY;
    logic [LEVEL_W-1:0] fifo_level;
    logic               tx_idle;

    // Caller / UART side
    modport master (
        output start_port, c, TX_READY,
        input  done_port, return_port, TX_DATA, TX_ENABLE, fifo_level, tx_idle
    );

    // Putchar backend side
    modport slave (
        input  start_port, c, TX_READY,
        output done_port, return_port, TX_DATA, TX_ENABLE, fifo_level, tx_idle
    );

endinterface

`default_nettype wire

// File: rtl/bambu_io_fifo.sv
// ============================================================================
//  Module   : bambu_io_fifo
//  Brief    : Register-array FIFO with registered level/full/empty flags;
//             read data appears the cycle after rd_en.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bambu_io_fifo #(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 16,
    localparam int LEVEL_W = $clog2(DEPTH) + 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    input  wire logic               wr_en_i,
    input  wire logic [DATA_W-1:0]  wr_data_i,
    input  wire logic               rd_en_i,
    output logic      [DATA_W-1:0]  rd_data_o,
    output logic      [LEVEL_W-1:0] level_o,
    output logic      [LEVEL_W-1:0] level_d_o,
    output logic                    full_o,
    output logic                    empty_o
);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic               full_q;
    logic               empty_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               w_do_wr;
    logic               w_do_rd;

    // Flags are registered, so a pop at the same edge never frees room for a push.
    assign w_do_wr = wr_en_i && !full_q;
    assign w_do_rd = rd_en_i && !empty_q;

    always_comb begin
        level_d = level_q;
        case ({w_do_wr, w_do_rd})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_rd) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            level_q <= level_d;
            full_q  <= (level_d == LEVEL_W'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;
    assign level_o   = level_q;
    assign level_d_o = level_d;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

`default_nettype wire

// File: rtl/bambu_putchar_fifo.sv
// ============================================================================
//  Module   : bambu_putchar_fifo
//  Brief    : Putchar backend: accept FSM pushes calls into a FIFO, drain FSM
//             feeds the UART. Macro PUTCHAR_CRLF_EN expands LF to CR,LF.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bambu_putchar_fifo
    import bambu_io_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input wire logic              clock,
    input wire logic              reset_n,
    bambu_putchar_fifo_if.slave   bus
);

    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    acc_state_t         acc_q, acc_d;
    tx_state_t          tx_q, tx_d;
    logic [DATA_W-1:0]  char_q, char_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  ret_q, ret_d;
    logic               tx_en_q, tx_en_d;
    logic               tx_idle_q, tx_idle_d;

    logic               w_wr_en;
    logic [DATA_W-1:0]  w_wr_data;
    logic               w_rd_en;
    logic [DATA_W-1:0]  w_rd_data;
    logic [LEVEL_W-1:0] w_level;
    logic [LEVEL_W-1:0] w_level_d;
    logic               w_full;
    logic               w_empty;

    bambu_io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en_i   (w_wr_en),
        .wr_data_i (w_wr_data),
        .rd_en_i   (w_rd_en),
        .rd_data_o (w_rd_data),
        .level_o   (w_level),
        .level_d_o (w_level_d),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    always_comb begin
        acc_d     = acc_q;
        char_d    = char_q;
        w_wr_en   = 1'b0;
        w_wr_data = char_q;
        done_d    = 1'b0;
        ret_d     = '0;
        case (acc_q)
            ACC_IDLE: begin
                if (bus.start_port) begin
                    char_d = bus.c;
`ifdef PUTCHAR_CRLF_EN
                    acc_d  = (bus.c == DATA_W'(CHAR_LF)) ? ACC_PUSH_CR : ACC_PUSH;
`else
                    acc_d  = ACC_PUSH;
`endif
                end
            end
`ifdef PUTCHAR_CRLF_EN
            ACC_PUSH_CR: begin
                if (!w_full) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = DATA_W'(CHAR_CR);
                    acc_d     = ACC_PUSH;
                end
            end
`endif
            ACC_PUSH: begin
                if (!w_full) begin
                    w_wr_en = 1'b1;
                    done_d  = 1'b1;
                    ret_d   = char_q;
                    acc_d   = ACC_IDLE;
                end
            end
            default: acc_d = ACC_IDLE;
        endcase
    end

    // TX_ENABLE is registered at the pop edge so it coincides with the FIFO read data.
    always_comb begin
        tx_d    = tx_q;
        w_rd_en = 1'b0;
        tx_en_d = 1'b0;
        case (tx_q)
            TX_IDLE: begin
                if (!w_empty && bus.TX_READY) begin
                    w_rd_en = 1'b1;
                    tx_en_d = 1'b1;
                    tx_d    = TX_SEND;
                end
            end
            TX_SEND: tx_d = TX_GAP;
            TX_GAP:  tx_d = TX_IDLE;
            default: tx_d = TX_IDLE;
        endcase
        tx_idle_d = (tx_d == TX_IDLE) && (w_level_d == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= ACC_IDLE;
            tx_q      <= TX_IDLE;
            char_q    <= '0;
            done_q    <= 1'b0;
            ret_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_idle_q <= 1'b1;
        end else begin
            acc_q     <= acc_d;
            tx_q      <= tx_d;
            char_q    <= char_d;
            done_q    <= done_d;
            ret_q     <= ret_d;
            tx_en_q   <= tx_en_d;
            tx_idle_q <= tx_idle_d;
        end
    end

    assign bus.done_port   = done_q;
    assign bus.return_port = ret_q;
    assign bus.TX_DATA     = w_rd_data;
    assign bus.TX_ENABLE   = tx_en_q;
    assign bus.fifo_level  = w_level;
    assign bus.tx_idle     = tx_idle_q;

endmodule

`default_nettype wire

// File: tb/tb_bambu_putchar_fifo.sv
// ============================================================================
//  Module   : tb_bambu_putchar_fifo
//  Brief    : Randomised self-checking bench with a queue-based character model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bambu_putchar_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bambu_putchar_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    bambu_putchar_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_ret  = 8'h00;
    int         done_cnt = 0;
    int         tx_cnt   = 0;
    int         n_calls  = 0;
    int         cyc      = 0;
    int         last_tx_cyc = -100;
    logic       prev_done   = 1'b0;
    logic       rand_rdy    = 1'b0;
    logic       rdy_fixed   = 1'b0;
    logic       rnd_bit     = 1'b0;
    logic       rdy_at_edge = 1'b0;

    assign bus.TX_READY = rand_rdy ? rnd_bit : rdy_fixed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: each call appends its emitted characters in order.
    task automatic issue(input logic [7:0] ch);
        bus.start_port = 1'b1;
        bus.c          = ch;
        exp_ret        = ch;
        n_calls++;
`ifdef PUTCHAR_CRLF_EN
        if (ch == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(ch);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bus.done_port) seen = 1'b1;
            else @(negedge clock);
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
        @(negedge clock);
    endtask

    task automatic call(input logic [7:0] ch, input int budget);
        issue(ch);
        @(negedge clock);
        bus.start_port = 1'b0;
        wait_done("call_done", budget);
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bus.tx_idle && exp_q.size() == 0) seen = 1'b1;
            else @(negedge clock);
        end
        check_eq("drain_idle", {31'd0, seen}, 32'd1);
    endtask

    always @(posedge clock) begin
        rdy_at_edge = bus.TX_READY;
        cyc++;
    end

    always @(negedge clock) begin
        if (rand_rdy) rnd_bit = 1'($urandom_range(0, 1));
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.done_port) begin
                check_eq("done_one_cycle", {31'd0, prev_done}, 32'd0);
                check_eq("return_port", {24'd0, bus.return_port}, {24'd0, exp_ret});
                done_cnt++;
            end else begin
                check_eq("return_idle_zero", {24'd0, bus.return_port}, 32'd0);
            end
            prev_done = bus.done_port;
            if (bus.TX_ENABLE) begin
                check_eq("tx_ready_at_pop", {31'd0, rdy_at_edge}, 32'd1);
                check_eq("tx_spacing", {31'd0, (cyc - last_tx_cyc) >= 3}, 32'd1);
                last_tx_cyc = cyc;
                tx_log.push_back(bus.TX_DATA);
                tx_cnt++;
                check_eq("tx_expected_pending", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0)
                    check_eq("tx_data_order", {24'd0, bus.TX_DATA}, {24'd0, exp_q.pop_front()});
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        logic [7:0] ch;

        bus.start_port = 1'b0;
        bus.c          = 8'h00;

        // Reset state
        repeat (2) @(negedge clock);
        check_eq("rst_done",    {31'd0, bus.done_port}, 32'd0);
        check_eq("rst_return",  {24'd0, bus.return_port}, 32'd0);
        check_eq("rst_txdata",  {24'd0, bus.TX_DATA}, 32'd0);
        check_eq("rst_txen",    {31'd0, bus.TX_ENABLE}, 32'd0);
        check_eq("rst_level",   {27'd0, bus.fifo_level}, 32'd0);
        check_eq("rst_txidle",  {31'd0, bus.tx_idle}, 32'd1);
        @(posedge clock); #2; reset_n = 1'b1;
        @(negedge clock);

        // Reset while a call is in flight
        bus.start_port = 1'b1;
        bus.c          = 8'h41;
        @(posedge clock); #2;
        reset_n        = 1'b0;
        bus.start_port = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check_eq("rstmid_no_done", done_cnt, 0);
        check_eq("rstmid_level",   {27'd0, bus.fifo_level}, 32'd0);
        check_eq("rstmid_txidle",  {31'd0, bus.tx_idle}, 32'd1);
        check_eq("rstmid_no_tx",   tx_cnt, 0);

        // Single character with exact call latency
        rdy_fixed = 1'b1;
        base = tx_cnt;
        issue(8'h48);
        @(negedge clock);
        bus.start_port = 1'b0;
        check_eq("lat_cycle1_done", {31'd0, bus.done_port}, 32'd0);
        @(negedge clock);
        check_eq("lat_cycle2_done", {31'd0, bus.done_port}, 32'd1);
        check_eq("lat_cycle2_ret",  {24'd0, bus.return_port}, 32'h48);
        @(negedge clock);
        wait_idle(50);
        check_eq("single_tx_count", tx_cnt - base, 1);
        check_eq("single_tx_data",  {24'd0, tx_log[tx_log.size()-1]}, 32'h48);

        // Fill to full, then stall a call until the UART drains one entry
        rdy_fixed = 1'b0;
        repeat (4) @(negedge clock);
        ch = 8'h00;
        while (exp_q.size() < DEPTH) begin
            call(ch, 20);
            ch = ch + 8'd1;
        end
        check_eq("full_level",  {27'd0, bus.fifo_level}, DEPTH);
        check_eq("full_txidle", {31'd0, bus.tx_idle}, 32'd0);
        issue(8'h55);
        @(negedge clock);
        bus.start_port = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clock);
        check_eq("full_stall_no_done", done_cnt - d0, 0);
        check_eq("full_stall_level",   {27'd0, bus.fifo_level}, DEPTH);
        rdy_fixed = 1'b1;
        wait_done("full_unstall_done", 40);
        wait_idle(400);
        check_eq("full_last_tx", {24'd0, tx_log[tx_log.size()-1]}, 32'h55);

        // Simultaneous push and pop at DEPTH-1
        rdy_fixed = 1'b0;
        repeat (4) @(negedge clock);
        ch = 8'h20;
        while (exp_q.size() < DEPTH - 1) begin
            call(ch, 20);
            ch = ch + 8'd1;
        end
        check_eq("simul_pre_level", {27'd0, bus.fifo_level}, DEPTH - 1);
        issue(8'h77);
        @(negedge clock);
        bus.start_port = 1'b0;
        rdy_fixed      = 1'b1;
        @(negedge clock);
        rdy_fixed = 1'b0;
        check_eq("simul_done",  {31'd0, bus.done_port}, 32'd1);
        check_eq("simul_level", {27'd0, bus.fifo_level}, DEPTH - 1);
        @(negedge clock);

        // Randomised back-pressure stream, long enough to wrap the pointers
        rand_rdy = 1'b1;
        for (int i = 0; i < 100 + 3 * DEPTH; i++) begin
            call(8'($urandom_range(0, 255)), 400);
        end
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        wait_idle(2000);
        check_eq("stream_level", {27'd0, bus.fifo_level}, 32'd0);

        // "A\n"
        tx_log.delete();
        call(8'h41, 20);
        call(8'h0A, 20);
        wait_idle(100);
`ifdef PUTCHAR_CRLF_EN
        check_eq("crlf_tx_count", tx_log.size(), 3);
        if (tx_log.size() == 3) begin
            check_eq("crlf_tx0", {24'd0, tx_log[0]}, 32'h41);
            check_eq("crlf_tx1", {24'd0, tx_log[1]}, 32'h0D);
            check_eq("crlf_tx2", {24'd0, tx_log[2]}, 32'h0A);
        end
`else
        check_eq("lf_tx_count", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check_eq("lf_tx0", {24'd0, tx_log[0]}, 32'h41);
            check_eq("lf_tx1", {24'd0, tx_log[1]}, 32'h0A);
        end
`endif
        check_eq("done_per_call", done_cnt, n_calls);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
